// File: rtl/ghb_ckpt_stack.sv
`default_nettype none
// ============================================================================
// Module  : ghb_ckpt_stack
// Brief   : Circular stack of branch checkpoints (history, PC, prediction)
//           with resolve, mispredict flush/recovery and in-order retire.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef GHB_SIZE
`define GHB_SIZE 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

module ghb_ckpt_stack #(
  parameter int DEPTH = 8,
  localparam int TW = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [`GHB_SIZE-1:0] alloc_ghbr,
  input  logic [`XLEN-1:0]     alloc_pc,
  input  logic                 alloc_pred,
  output logic                 alloc_ready,
  output logic [TW-1:0]        alloc_tag,
  input  logic                 res_en,
  input  logic [TW-1:0]        res_tag,
  input  logic                 res_taken,
  output logic                 X_branch,
  output logic                 X_taken,
  output logic [`XLEN-1:0]     X_PC,
  output logic [`GHB_SIZE-1:0] X_ghbr,
  output logic                 mispredict,
  output logic [`GHB_SIZE-1:0] recover_ghbr,
  input  logic                 retire_en,
  output logic                 retire_ready,
  output logic [TW:0]          count,
  output logic                 err
);

  localparam int          c_G    = `GHB_SIZE;
  localparam int          c_XLEN = `XLEN;
  localparam logic [TW:0] c_FULL = (TW+1)'(DEPTH);
  localparam logic [TW:0] c_ONE  = (TW+1)'(1);

  logic [TW:0]       r_head, r_tail;
  logic [TW-1:0]     w_head_idx, w_tail_idx;
  logic [DEPTH-1:0]  w_valid, w_resolved, w_pred;
  logic [c_G-1:0]    w_ghbr [DEPTH];
  logic [c_XLEN-1:0] w_pc   [DEPTH];

  logic          w_res_ok, w_mis, w_push, w_retire;
  logic [TW-1:0] w_res_age;
  logic [TW:0]   w_res_ptr;

  assign w_head_idx   = r_head[TW-1:0];
  assign w_tail_idx   = r_tail[TW-1:0];
  assign count        = r_tail - r_head;
  assign alloc_ready  = (count != c_FULL);
  assign alloc_tag    = w_tail_idx;
  assign retire_ready = w_valid[w_head_idx] & w_resolved[w_head_idx];

  assign w_res_ok = res_en & w_valid[res_tag] & ~w_resolved[res_tag];
  assign w_mis    = w_res_ok & (res_taken != w_pred[res_tag]);
  assign w_push   = alloc_en & alloc_ready & ~w_mis;
  assign w_retire = retire_en & retire_ready;

  // Age relative to head gives the absolute (wrap-correct) pointer of res_tag.
  assign w_res_age = res_tag - w_head_idx;
  assign w_res_ptr = r_head + {1'b0, w_res_age};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [TW-1:0] c_IDX = TW'(gi);
    logic              r_v, r_res, r_p;
    logic [c_G-1:0]    r_g;
    logic [c_XLEN-1:0] r_pcv;
    logic [TW-1:0]     w_age;
    logic              w_kill;

    assign w_age  = c_IDX - w_head_idx;
    assign w_kill = w_mis & (w_age > w_res_age);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_v   <= 1'b0;
        r_res <= 1'b0;
        r_p   <= 1'b0;
        r_g   <= '0;
        r_pcv <= '0;
      end else if (w_push && (w_tail_idx == c_IDX)) begin
        r_v   <= 1'b1;
        r_res <= 1'b0;
        r_p   <= alloc_pred;
        r_g   <= alloc_ghbr;
        r_pcv <= alloc_pc;
      end else begin
        if (w_kill || (w_retire && (w_head_idx == c_IDX)))
          r_v <= 1'b0;
        if (w_res_ok && (res_tag == c_IDX))
          r_res <= 1'b1;
      end
    end

    assign w_valid[gi]    = r_v;
    assign w_resolved[gi] = r_res;
    assign w_pred[gi]     = r_p;
    assign w_ghbr[gi]     = r_g;
    assign w_pc[gi]       = r_pcv;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      X_branch     <= 1'b0;
      X_taken      <= 1'b0;
      X_PC         <= '0;
      X_ghbr       <= '0;
      mispredict   <= 1'b0;
      recover_ghbr <= '0;
      err          <= 1'b0;
    end else begin
      if (w_retire)
        r_head <= r_head + c_ONE;
      if (w_mis)
        r_tail <= w_res_ptr + c_ONE;
      else if (w_push)
        r_tail <= r_tail + c_ONE;

      X_branch     <= w_res_ok;
      X_taken      <= w_res_ok & res_taken;
      X_PC         <= w_res_ok ? w_pc[res_tag] : '0;
      X_ghbr       <= w_res_ok ? w_ghbr[res_tag] : '0;
      mispredict   <= w_mis;
      recover_ghbr <= w_mis ? {w_ghbr[res_tag][c_G-2:0], res_taken} : '0;
      err          <= err | (res_en & ~w_res_ok);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ghb_ckpt_stack.sv
`default_nettype none
// ============================================================================
// Module  : tb_ghb_ckpt_stack
// Brief   : Directed self-checking bench for ghb_ckpt_stack (DEPTH=4).
// Revision: 1.0 - initial release
// ============================================================================
`ifndef GHB_SIZE
`define GHB_SIZE 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_ghb_ckpt_stack;
  localparam int DEPTH = 4;
  localparam int TW    = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 alloc_en = 1'b0;
  logic [`GHB_SIZE-1:0] alloc_ghbr = '0;
  logic [`XLEN-1:0]     alloc_pc = '0;
  logic                 alloc_pred = 1'b0;
  logic                 alloc_ready;
  logic [TW-1:0]        alloc_tag;
  logic                 res_en = 1'b0;
  logic [TW-1:0]        res_tag = '0;
  logic                 res_taken = 1'b0;
  logic                 X_branch, X_taken, mispredict, retire_ready, err;
  logic [`XLEN-1:0]     X_PC;
  logic [`GHB_SIZE-1:0] X_ghbr, recover_ghbr;
  logic                 retire_en = 1'b0;
  logic [TW:0]          count;

  int n_chk  = 0;
  int n_fail = 0;

  ghb_ckpt_stack #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alloc_en(alloc_en), .alloc_ghbr(alloc_ghbr), .alloc_pc(alloc_pc),
    .alloc_pred(alloc_pred), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_en(res_en), .res_tag(res_tag), .res_taken(res_taken),
    .X_branch(X_branch), .X_taken(X_taken), .X_PC(X_PC), .X_ghbr(X_ghbr),
    .mispredict(mispredict), .recover_ghbr(recover_ghbr),
    .retire_en(retire_en), .retire_ready(retire_ready),
    .count(count), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [31:0] pc, input logic p);
    alloc_en = 1'b1; alloc_ghbr = g; alloc_pc = pc; alloc_pred = p;
    tick();
    alloc_en = 1'b0;
  endtask

  task automatic resolve(input logic [TW-1:0] t, input logic tk);
    res_en = 1'b1; res_tag = t; res_taken = tk;
    tick();
    res_en = 1'b0;
  endtask

  task automatic retire();
    retire_en = 1'b1;
    tick();
    retire_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_retire_ready", retire_ready, 0);
    chk("rst_X_branch", X_branch, 0);
    chk("rst_X_ghbr", X_ghbr, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_recover", recover_ghbr, 0);
    chk("rst_err", err, 0);
    #10 reset = 1'b1;
    tick();

    // Fill, then overflow push
    for (int i = 0; i < 4; i++) begin
      chk("fill_tag", alloc_tag, i);
      push(4'(i), 32'h100 + i, 1'b1);
    end
    chk("full_count", count, 4);
    chk("full_ready", alloc_ready, 0);
    push(4'hF, 32'h1FF, 1'b0);
    chk("drop_count", count, 4);
    chk("drop_tag", alloc_tag, 0);
    do_reset();

    // Correct prediction
    push(4'b1010, 32'h200, 1'b1);
    resolve(2'd0, 1'b1);
    chk("ok_X_branch", X_branch, 1);
    chk("ok_X_ghbr", X_ghbr, 4'b1010);
    chk("ok_X_taken", X_taken, 1);
    chk("ok_X_PC", X_PC, 32'h200);
    chk("ok_mispredict", mispredict, 0);
    tick();
    chk("ok_X_branch_pulse", X_branch, 0);
    chk("ok_retire_ready", retire_ready, 1);
    retire();
    chk("ok_retired_count", count, 0);
    chk("ok_retire_ready_after", retire_ready, 0);
    do_reset();

    // Mispredict flush
    push(4'b0001, 32'h300, 1'b1);
    push(4'b0110, 32'h304, 1'b0);
    push(4'b0011, 32'h308, 1'b1);
    push(4'b0111, 32'h30C, 1'b1);
    resolve(2'd1, 1'b1);
    chk("mp_mispredict", mispredict, 1);
    chk("mp_recover", recover_ghbr, 4'b1101);
    chk("mp_X_branch", X_branch, 1);
    chk("mp_X_ghbr", X_ghbr, 4'b0110);
    chk("mp_count", count, 2);
    chk("mp_alloc_tag", alloc_tag, 2);
    tick();
    chk("mp_pulse", mispredict, 0);
    resolve(2'd3, 1'b1);
    chk("mp_killed_tag3_X_branch", X_branch, 0);
    chk("mp_killed_tag3_err", err, 1);
    push(4'b0000, 32'h310, 1'b1);
    alloc_en = 1'b1; alloc_ghbr = 4'hE; alloc_pc = 32'h314; alloc_pred = 1'b0;
    res_en = 1'b1; res_tag = 2'd2; res_taken = 1'b0;
    tick();
    alloc_en = 1'b0; res_en = 1'b0;
    chk("mp2_mispredict", mispredict, 1);
    chk("mp2_recover", recover_ghbr, 4'b0000);
    chk("mp2_push_discard_count", count, 3);
    chk("mp2_alloc_tag", alloc_tag, 3);
    do_reset();
    chk("reset_clears_err", err, 0);

    // Wrap-around
    for (int i = 0; i < 4; i++) push(4'(i), 32'h400 + i, 1'b0);
    res_en = 1'b1; res_tag = 2'd0; res_taken = 1'b0; retire_en = 1'b1;
    tick();
    res_en = 1'b0; retire_en = 1'b0;
    chk("same_cycle_resolve_no_retire", count, 4);
    chk("wrap_ready_next", retire_ready, 1);
    retire();
    chk("wrap_count3", count, 3);
    chk("wrap_tag0", alloc_tag, 0);
    push(4'h8, 32'h410, 1'b0);
    chk("wrap_full_count", count, 4);
    chk("wrap_full_ready", alloc_ready, 0);
    for (int i = 1; i < 4; i++) resolve(2'(i), 1'b0);
    for (int i = 1; i < 4; i++) retire();
    chk("wrap_count1", count, 1);
    for (int i = 1; i < 4; i++) begin
      chk("wrap_tag_seq", alloc_tag, i);
      push(4'(i), 32'h420 + i, 1'b1);
    end
    chk("wrap_full2_count", count, 4);
    chk("wrap_full2_ready", alloc_ready, 0);
    resolve(2'd0, 1'b0);
    alloc_en = 1'b1; retire_en = 1'b1;
    tick();
    alloc_en = 1'b0; retire_en = 1'b0;
    chk("full_push_with_retire_count", count, 3);
    chk("full_push_with_retire_tag", alloc_tag, 0);
    do_reset();

    // Bad resolves
    resolve(2'd2, 1'b1);
    chk("bad_empty_X_branch", X_branch, 0);
    chk("bad_empty_err", err, 1);
    tick(); tick();
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    for (int i = 0; i < 3; i++) push(4'(i), 32'h500 + i, 1'b1);
    resolve(2'd2, 1'b1);
    chk("good_X_branch", X_branch, 1);
    chk("good_err", err, 0);
    resolve(2'd2, 1'b1);
    chk("dup_X_branch", X_branch, 0);
    chk("dup_err", err, 1);

    // Asynchronous reset between edges
    chk("pre_async_count", count, 3);
    #3 reset = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_ready", alloc_ready, 1);
    chk("async_tag", alloc_tag, 0);
    chk("async_err", err, 0);
    chk("async_retire_ready", retire_ready, 0);
    #2 reset = 1'b1;
    tick();
    chk("post_reset_tag", alloc_tag, 0);
    push(4'h3, 32'h600, 1'b0);
    chk("post_reset_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
